sram_read_arbiter: RTL
======================

Name: sram_read_arbiter

Overview:
- Round-robin front end for the shared SPRAM read port of sram_bus.
- Latches one-cycle read strobes from up to REQUESTER_COUNT clients, each with its own address.
- Issues one read at a time on a level request / done-strobe handshake to the SRAM bus, then returns the data with a per-requester completion strobe.
- Replaces fixed-index priority with fair rotation, and adds overrun and timeout reporting.

Parameters:
- ADDRESS_BUS_WIDTH, 16, width of every address.
- DATA_BUS_WIDTH, 16, width of read data.
- REQUESTER_COUNT, 4, number of clients (2..8).
- INDEX_WIDTH, 2, width of grant index (clog2 of REQUESTER_COUNT, min 1).
- TIMEOUT_CYCLES, 15, max cycles in WAIT before abort (1..255).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous active-high reset.
- req_strobes  in  REQUESTER_COUNT  one-cycle read request per client.
- req_addresses  in  REQUESTER_COUNT*ADDRESS_BUS_WIDTH  client i address in bits [i*AW +: AW], sampled with its strobe.
- resp_strobes  out  REQUESTER_COUNT  one-cycle completion per client.
- resp_data  out  DATA_BUS_WIDTH  read data, valid with resp_strobes and held until next completion.
- resp_error  out  1  high with the resp_strobes bit when the read timed out; resp_data then holds 0.
- mem_read_request  out  1  level request to SRAM bus.
- mem_read_address  out  ADDRESS_BUS_WIDTH  address for current request, stable while mem_read_request is high.
- mem_read_done  in  1  one-cycle strobe from SRAM bus, data valid.
- mem_read_data  in  DATA_BUS_WIDTH  SRAM read data.
- overrun_flags  out  REQUESTER_COUNT  sticky per client: strobe arrived while already pending.
- overrun_clear  in  1  synchronous clear of overrun_flags.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset (async) clears all outputs, pending bits, address latches, overrun_flags and counter. State goes to IDLE and rr_pointer to REQUESTER_COUNT-1, so client 0 is served first.
- Capture:
  - req_strobes[i] with pending[i]=0 sets pending[i] and latches client i's address next cycle.
  - A strobe with pending[i]=1 is dropped: the latched address is kept and overrun_flags[i] is set.
  - If the strobe coincides with the completion of client i, the pending bit is re-set with the new address. This is not an overrun.
- overrun_clear and a new overrun in the same cycle leave the flag set.
- States: IDLE, WAIT, RESPOND.
- IDLE:
  - If any pending bit is set, select the first pending index searching upward from rr_pointer+1, with modulo wrap.
  - Register grant, mem_read_address and mem_read_request=1, then go to WAIT.
  - A request captured in cycle N can be issued in cycle N+1 at the earliest, with mem_read_request high from N+2.
- WAIT:
  - Hold mem_read_request and address.
  - The counter increments each cycle.
  - On mem_read_done: latch mem_read_data, drop mem_read_request, go to RESPOND.
  - If the counter reaches TIMEOUT_CYCLES without done: drop the request, set error_pending, go to RESPOND.
  - mem_read_done outside WAIT is ignored.
- RESPOND, one cycle:
  - Assert resp_strobes[grant] and drive resp_data (0 on timeout) and resp_error.
  - Clear pending[grant], set rr_pointer=grant, clear the counter, go to IDLE.
- Throughput: back-to-back grants have at least one IDLE cycle between RESPOND and the next request assertion. At most one resp_strobes bit is high at a time.
- Reset mid-operation aborts everything immediately. No response is generated for pending or in-flight reads.

Test Plan:
- Single read: strobe client 2 with addr 0x4123, done 2 cycles after request with data 0xBEEF -> mem_read_address=0x4123, resp_strobes=0b0100, resp_data=0xBEEF, resp_error=0.
- Fairness: all 4 clients strobe in the same cycle after reset -> grant order 0,1,2,3. Then strobe clients 0 and 3 together -> 0 is served before 3 (pointer at 3, wraps to 0).
- Overrun: client 1 strobes twice before service with addr 0x0010 then 0x0020 -> memory sees 0x0010 only, overrun_flags[1]=1. overrun_clear -> 0.
- Coincident re-request: client 0 strobes in its RESPOND cycle with addr 0x8000 -> new pending accepted, second read issued at 0x8000, overrun_flags stay 0.
- Timeout: never assert mem_read_done -> mem_read_request drops after 15 WAIT cycles, resp_strobes bit pulses with resp_error=1 and resp_data=0. The next pending client is then served.
- Reset mid-WAIT: assert rst while mem_read_request=1 -> all outputs 0 immediately. No resp_strobes after release, and a late mem_read_done is ignored.

Source files
------------

// File: rtl/sram_read_arbiter_if.sv
// Client-side and SRAM-side signal bundle for the round-robin SRAM read arbiter.
// The master modport is the arbiter's view; slave is the surrounding clients and memory.
interface sram_read_arbiter_if #(
  parameter int unsigned ADDRESS_BUS_WIDTH = 16,
  parameter int unsigned DATA_BUS_WIDTH    = 16,
  parameter int unsigned REQUESTER_COUNT   = 4
);
  logic [REQUESTER_COUNT-1:0]                   req_strobes;
  logic [REQUESTER_COUNT*ADDRESS_BUS_WIDTH-1:0] req_addresses;
  logic [REQUESTER_COUNT-1:0]                   resp_strobes;
  logic [DATA_BUS_WIDTH-1:0]                    resp_data;
  logic                                         resp_error;
  logic                                         mem_read_request;
  logic [ADDRESS_BUS_WIDTH-1:0]                 mem_read_address;
  logic                                         mem_read_done;
  logic [DATA_BUS_WIDTH-1:0]                    mem_read_data;
  logic [REQUESTER_COUNT-1:0]                   overrun_flags;
  logic                                         overrun_clear;
  logic                                         busy;

  modport master (
    input  req_strobes, req_addresses, mem_read_done, mem_read_data, overrun_clear,
    output resp_strobes, resp_data, resp_error, mem_read_request, mem_read_address,
           overrun_flags, busy
  );

  modport slave (
    output req_strobes, req_addresses, mem_read_done, mem_read_data, overrun_clear,
    input  resp_strobes, resp_data, resp_error, mem_read_request, mem_read_address,
           overrun_flags, busy
  );
endinterface

// File: rtl/sram_read_arbiter.sv
// Round-robin arbiter serialising latched client read strobes onto one SRAM read port,
// with per-client completion strobes, sticky overrun flags and a WAIT timeout.
module sram_read_arbiter #(
  parameter int unsigned ADDRESS_BUS_WIDTH = 16,
  parameter int unsigned DATA_BUS_WIDTH    = 16,
  parameter int unsigned REQUESTER_COUNT   = 4,
  parameter int unsigned INDEX_WIDTH       = 2,
  parameter int unsigned TIMEOUT_CYCLES    = 15
) (
  input logic           clk,
  input logic           rst,
  sram_read_arbiter_if.master bus
);
  localparam int unsigned AW = ADDRESS_BUS_WIDTH;
  localparam int unsigned DW = DATA_BUS_WIDTH;
  localparam int unsigned RC = REQUESTER_COUNT;
  localparam int unsigned IW = INDEX_WIDTH;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t         state_q;
  logic [RC-1:0]  pending_q, pending_d;
  logic [RC-1:0]  overrun_q, overrun_d;
  logic [RC-1:0]  accept_c;
  logic [AW-1:0]  addr_q [RC];
  logic [IW-1:0]  rr_q;
  logic [IW-1:0]  grant_q;
  logic [IW-1:0]  sel_idx_c;
  logic           sel_found_c;
  logic [CW-1:0]  count_q;
  logic           mem_req_q;
  logic [AW-1:0]  mem_addr_q;
  logic [RC-1:0]  resp_strobes_q;
  logic [DW-1:0]  resp_data_q;
  logic           resp_error_q;
  logic           busy_q;

  assign bus.resp_strobes     = resp_strobes_q;
  assign bus.resp_data        = resp_data_q;
  assign bus.resp_error       = resp_error_q;
  assign bus.mem_read_request = mem_req_q;
  assign bus.mem_read_address = mem_addr_q;
  assign bus.overrun_flags    = overrun_q;
  assign bus.busy             = busy_q;

  // A client completing this cycle may re-request without it counting as an overrun.
  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    accept_c  = '0;
    if (bus.overrun_clear) overrun_d = '0;
    if (state_q == RESPOND) pending_d[grant_q] = 1'b0;
    for (int i = 0; i < int'(RC); i++) begin
      if (bus.req_strobes[i]) begin
        if (!pending_q[i] || (state_q == RESPOND && grant_q == IW'(i))) begin
          accept_c[i]  = 1'b1;
          pending_d[i] = 1'b1;
        end else begin
          overrun_d[i] = 1'b1;
        end
      end
    end
  end

  // First pending index above rr_q, wrapping; descending scan so the nearest wins.
  always_comb begin
    sel_found_c = 1'b0;
    sel_idx_c   = '0;
    for (int k = int'(RC); k >= 1; k--) begin
      if (pending_q[IW'((int'(rr_q) + k) % int'(RC))]) begin
        sel_found_c = 1'b1;
        sel_idx_c   = IW'((int'(rr_q) + k) % int'(RC));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      pending_q      <= '0;
      overrun_q      <= '0;
      rr_q           <= IW'(RC - 1);
      grant_q        <= '0;
      count_q        <= '0;
      mem_req_q      <= 1'b0;
      mem_addr_q     <= '0;
      resp_strobes_q <= '0;
      resp_data_q    <= '0;
      resp_error_q   <= 1'b0;
      busy_q         <= 1'b0;
      for (int i = 0; i < int'(RC); i++) addr_q[i] <= '0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      for (int i = 0; i < int'(RC); i++) begin
        if (accept_c[i]) addr_q[i] <= bus.req_addresses[i*AW +: AW];
      end

      case (state_q)
        IDLE: begin
          if (sel_found_c) begin
            grant_q    <= sel_idx_c;
            mem_addr_q <= addr_q[sel_idx_c];
            mem_req_q  <= 1'b1;
            count_q    <= '0;
            busy_q     <= 1'b1;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_read_done) begin
            mem_req_q      <= 1'b0;
            resp_data_q    <= bus.mem_read_data;
            resp_error_q   <= 1'b0;
            resp_strobes_q <= RC'(1) << grant_q;
            state_q        <= RESPOND;
          end else if (count_q + CW'(1) == CW'(TIMEOUT_CYCLES)) begin
            mem_req_q      <= 1'b0;
            resp_data_q    <= '0;
            resp_error_q   <= 1'b1;
            resp_strobes_q <= RC'(1) << grant_q;
            state_q        <= RESPOND;
          end else begin
            count_q <= count_q + CW'(1);
          end
        end
        RESPOND: begin
          resp_strobes_q <= '0;
          resp_error_q   <= 1'b0;
          rr_q           <= grant_q;
          count_q        <= '0;
          busy_q         <= 1'b0;
          state_q        <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule
